// File: rtl/l2_pkg.sv
// Shared L2 definitions: line geometry, load_manager state encoding and
// helpers that compose per-word bus and cache-RAM addresses.
package l2_pkg;

  localparam int unsigned LINE_WORDS     = 16;
  localparam int unsigned WORD_IDX_W     = 4;
  localparam int unsigned MEM_RD_LATENCY = 2;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned PADDR_W        = 32;
  localparam int unsigned GADDR_W        = 8;
  localparam int unsigned LINE_TAG_W     = PADDR_W - WORD_IDX_W - 2;
  localparam int unsigned GROUP_W        = GADDR_W - WORD_IDX_W;
  localparam int unsigned DRAIN_W        = $clog2(MEM_RD_LATENCY + 1);

  typedef logic [WORD_IDX_W-1:0] word_idx_t;

  localparam word_idx_t LAST_WORD = WORD_IDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WFETCH,
    WDRAIN,
    WBUS,
    RBUS,
    DONE
  } lm_state_e;

  // Byte address of word idx within the line whose tag is pa[31:6].
  function automatic logic [PADDR_W-1:0] bus_word_addr(input logic [LINE_TAG_W-1:0] line,
                                                        input word_idx_t idx);
    return {line, idx, 2'b00};
  endfunction

  // Cache RAM word index of word idx within the group ga[7:4].
  function automatic logic [GADDR_W-1:0] ram_word_addr(input logic [GROUP_W-1:0] grp,
                                                        input word_idx_t idx);
    return {grp, idx};
  endfunction

endpackage

// File: rtl/load_line_buffer.sv
// 16x32 line staging buffer: one synchronous write port, one combinational
// read port.
//   clk            : clock
//   we/waddr/wdata : write port
//   raddr/rdata_c  : read port (combinational)
module load_line_buffer
  import l2_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  word_idx_t         waddr,
  input  logic [DATA_W-1:0] wdata,
  input  word_idx_t         raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem_q [LINE_WORDS];

  // Storage needs no reset: every word is written before it is read.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/load_manager.sv
// Cache-line transfer engine: writes one 16-word line from the cache data RAM
// to the bus (wtrig) or fills one line from the bus into the RAM (rtrig).
//   clk, reset                     : clock, async active-high reset
//   wtrig, rtrig                   : start writeback / fill (sampled in IDLE)
//   physical_addr, group_addr      : line bus address / RAM line base
//   bus_rreq, bus_wreq             : burst requests
//   bus_acc, bus_busy              : grant / stall
//   bus_addr, bus_rdata, bus_wdata : beat address and data
//   mem_wreq, mem_waddr, mem_wdata : RAM write port
//   mem_raddr, mem_rdata           : RAM read port (MEM_RD_LATENCY cycles)
//   fault, finish                  : one-cycle status pulses
module load_manager
  import l2_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wtrig,
  input  logic               rtrig,
  input  logic [PADDR_W-1:0] physical_addr,
  input  logic [GADDR_W-1:0] group_addr,
  output logic               bus_rreq,
  output logic               bus_wreq,
  input  logic               bus_acc,
  input  logic               bus_busy,
  output logic [PADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0]  bus_rdata,
  output logic [DATA_W-1:0]  bus_wdata,
  output logic               mem_wreq,
  output logic [GADDR_W-1:0] mem_raddr,
  output logic [GADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               fault,
  output logic               finish
);

  lm_state_e                 state_q, state_d;
  logic [LINE_TAG_W-1:0]     line_q, line_d;
  logic [GROUP_W-1:0]        grp_q, grp_d;
  word_idx_t                 fetch_q, fetch_d;
  word_idx_t                 cap_q, cap_d;
  word_idx_t                 beat_q, beat_d;
  logic [DRAIN_W-1:0]        drain_q, drain_d;
  logic [MEM_RD_LATENCY-1:0] pipe_q, pipe_d;
  logic                      any_beat_q, any_beat_d;
  logic                      fault_d;
  logic [GADDR_W-1:0]        raddr_d;
  logic                      in_burst, beat_done, fill_beat, cap_we;
  logic [DATA_W-1:0]         buf_rdata_c;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^{physical_addr[5:0], group_addr[3:0]};

  // A beat completes only while our own request is up (state is WBUS/RBUS).
  assign in_burst  = (state_q == WBUS) || (state_q == RBUS);
  assign beat_done = in_burst && bus_acc && !bus_busy;
  assign fill_beat = beat_done && (state_q == RBUS);
  // RAM read data arrives when the issue marker reaches the pipe's last stage.
  assign cap_we    = pipe_q[MEM_RD_LATENCY-1];

  load_line_buffer u_buf (
    .clk     (clk),
    .we      (cap_we),
    .waddr   (cap_q),
    .wdata   (mem_rdata),
    .raddr   (beat_d),
    .rdata_c (buf_rdata_c)
  );

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    grp_d      = grp_q;
    fetch_d    = fetch_q;
    beat_d     = beat_q;
    drain_d    = drain_q;
    any_beat_d = any_beat_q;
    fault_d    = 1'b0;
    raddr_d    = mem_raddr;
    cap_d      = cap_we ? cap_q + WORD_IDX_W'(1) : cap_q;
    pipe_d     = {pipe_q[MEM_RD_LATENCY-2:0], (state_q == WFETCH)};

    case (state_q)
      IDLE: begin
        if (wtrig && rtrig) begin
          fault_d = 1'b1;
        end else if (wtrig || rtrig) begin
          state_d    = wtrig ? WFETCH : RBUS;
          line_d     = physical_addr[PADDR_W-1:WORD_IDX_W+2];
          grp_d      = group_addr[GADDR_W-1:WORD_IDX_W];
          fetch_d    = '0;
          cap_d      = '0;
          beat_d     = '0;
          drain_d    = '0;
          any_beat_d = 1'b0;
          if (wtrig) raddr_d = ram_word_addr(group_addr[GADDR_W-1:WORD_IDX_W], '0);
        end
      end
      WFETCH: begin
        if (fetch_q == LAST_WORD) begin
          state_d = WDRAIN;
        end else begin
          fetch_d = fetch_q + WORD_IDX_W'(1);
          raddr_d = ram_word_addr(grp_q, fetch_d);
        end
      end
      WDRAIN: begin
        if (drain_q == DRAIN_W'(MEM_RD_LATENCY - 1)) state_d = WBUS;
        else drain_d = drain_q + DRAIN_W'(1);
      end
      WBUS, RBUS: begin
        if (beat_done) begin
          any_beat_d = 1'b1;
          beat_d     = beat_q + WORD_IDX_W'(1);
          if (beat_q == LAST_WORD) state_d = DONE;
        end else if (any_beat_q && !bus_acc) begin
          // Grant lost mid-burst: abandon the line.
          fault_d = 1'b1;
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      grp_q      <= '0;
      fetch_q    <= '0;
      cap_q      <= '0;
      beat_q     <= '0;
      drain_q    <= '0;
      pipe_q     <= '0;
      any_beat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      grp_q      <= grp_d;
      fetch_q    <= fetch_d;
      cap_q      <= cap_d;
      beat_q     <= beat_d;
      drain_q    <= drain_d;
      pipe_q     <= pipe_d;
      any_beat_q <= any_beat_d;
    end
  end

  // Registered outputs, driven from the next-state view so they line up
  // with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_wreq  <= 1'b0;
      bus_rreq  <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      mem_wreq  <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      fault     <= 1'b0;
      finish    <= 1'b0;
    end else begin
      bus_wreq  <= (state_d == WBUS);
      bus_rreq  <= (state_d == RBUS);
      bus_addr  <= ((state_d == WBUS) || (state_d == RBUS)) ? bus_word_addr(line_d, beat_d) : '0;
      bus_wdata <= (state_d == WBUS) ? buf_rdata_c : '0;
      mem_wreq  <= fill_beat;
      mem_raddr <= raddr_d;
      if (fill_beat) begin
        mem_waddr <= ram_word_addr(grp_q, beat_q);
        mem_wdata <= bus_rdata;
      end
      fault     <= fault_d;
      finish    <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_load_manager.sv
// Scoreboard bench for load_manager: stimulus pushes expected beats, RAM
// writes and status events; a negedge monitor pops and compares them.
module tb_load_manager;

  logic        clk = 1'b0;
  logic        reset, wtrig, rtrig, bus_acc, bus_busy;
  logic [31:0] physical_addr, bus_rdata, mem_rdata;
  logic [7:0]  group_addr;
  logic        bus_rreq, bus_wreq, mem_wreq, fault, finish;
  logic [31:0] bus_addr, bus_wdata, mem_wdata;
  logic [7:0]  mem_raddr, mem_waddr;

  always #5 clk = ~clk;

  load_manager dut (
    .clk(clk), .reset(reset), .wtrig(wtrig), .rtrig(rtrig),
    .physical_addr(physical_addr), .group_addr(group_addr),
    .bus_rreq(bus_rreq), .bus_wreq(bus_wreq), .bus_acc(bus_acc), .bus_busy(bus_busy),
    .bus_addr(bus_addr), .bus_rdata(bus_rdata), .bus_wdata(bus_wdata),
    .mem_wreq(mem_wreq), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .fault(fault), .finish(finish)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; } xfer_t;

  xfer_t       wq[$];   // expected write beats
  xfer_t       mq[$];   // expected RAM writes
  logic [31:0] rq[$];   // expected read-beat addresses
  int          evq[$];  // expected events: 0 finish, 1 fault

  int total = 0, bad = 0;
  int beats_seen = 0;
  int busy_mode = 0, stall_at = -1, stall_left = 0, abort_at = -1;
  bit stall_done = 1'b0;

  // Cache RAM model: data = address + 0x1234, two cycles after the address.
  logic [7:0] ra1, ra2;
  always @(posedge clk) begin
    ra1 <= mem_raddr;
    ra2 <= ra1;
  end
  assign mem_rdata = 32'(ra2) + 32'h1234;

  // Bus read model: k-th completed read beat returns rd_base + k.
  int unsigned rd_beats;
  logic [31:0] rd_base = 32'd0;
  always @(posedge clk) begin
    if (reset) rd_beats <= 0;
    else if (bus_rreq && bus_acc && !bus_busy) rd_beats <= rd_beats + 1;
  end
  assign bus_rdata = rd_base + 32'(rd_beats);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: unexpected, value %h, nothing queued", nm, act);
  endtask

  // Monitor.
  logic        prev_req = 1'b0, prev_done = 1'b0, mdone;
  logic [31:0] prev_addr, prev_wdata;
  xfer_t       me;
  int          ev;
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      mdone = (bus_wreq || bus_rreq) && bus_acc && !bus_busy;
      if (prev_req && !prev_done && (bus_wreq || bus_rreq)) begin
        check("hold_addr", bus_addr, prev_addr);
        check("hold_wdata", bus_wdata, prev_wdata);
      end
      if (bus_wreq && mdone) begin
        beats_seen++;
        if (wq.size() == 0) unexpected("wbeat", bus_addr);
        else begin
          me = wq.pop_front();
          check("wb_addr", bus_addr, me.a);
          check("wb_data", bus_wdata, me.d);
        end
      end
      if (bus_rreq && mdone) begin
        beats_seen++;
        if (rq.size() == 0) unexpected("rbeat", bus_addr);
        else check("rd_addr", bus_addr, rq.pop_front());
      end
      if (mem_wreq) begin
        if (mq.size() == 0) unexpected("ram_write", 32'(mem_waddr));
        else begin
          me = mq.pop_front();
          check("ram_waddr", 32'(mem_waddr), me.a);
          check("ram_wdata", mem_wdata, me.d);
        end
      end
      if (finish || fault) begin
        if (evq.size() == 0) unexpected("event", 32'({fault, finish}));
        else begin
          ev = evq.pop_front();
          check("event_kind", 32'({fault, finish}), (ev == 1) ? 32'd2 : 32'd1);
          check("event_req_low", 32'({bus_wreq, bus_rreq}), 32'd0);
        end
      end
      prev_req   = bus_wreq || bus_rreq;
      prev_done  = mdone;
      prev_addr  = bus_addr;
      prev_wdata = bus_wdata;
    end
  end

  // One clock: inputs change 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (abort_at >= 0 && beats_seen == abort_at) bus_acc = 1'b0;
    if (stall_at > 0 && !stall_done && beats_seen == stall_at) begin
      stall_left = 10;
      stall_done = 1'b1;
    end
    if (stall_left > 0) begin
      bus_busy = 1'b1;
      stall_left--;
    end else begin
      bus_busy = (busy_mode != 0) && ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic push_wb(input logic [31:0] pa, input logic [7:0] ga);
    for (int i = 0; i < 16; i++) begin
      xfer_t e;
      e.a = (pa & 32'hFFFF_FFC0) + 32'(4 * i);
      e.d = 32'(ga & 8'hF0) + 32'(i) + 32'h1234;
      wq.push_back(e);
    end
    evq.push_back(0);
  endtask

  task automatic push_fill(input logic [31:0] pa, input logic [7:0] ga,
                           input logic [31:0] base, input int n, input int evk);
    for (int i = 0; i < n; i++) begin
      xfer_t e;
      rq.push_back((pa & 32'hFFFF_FFC0) + 32'(4 * i));
      e.a = 32'(ga & 8'hF0) + 32'(i);
      e.d = base + 32'(i);
      mq.push_back(e);
    end
    evq.push_back(evk);
  endtask

  task automatic start(input logic w, input logic r, input logic [31:0] pa, input logic [7:0] ga);
    beats_seen    = 0;
    physical_addr = pa;
    group_addr    = ga;
    wtrig         = w;
    rtrig         = r;
    cycle();
    wtrig         = 1'b0;
    rtrig         = 1'b0;
    physical_addr = $urandom;
    group_addr    = 8'($urandom);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (evq.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    if (evq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: %0d events still pending after %0d cycles", nm, evq.size(), budget);
    end
    repeat (2) cycle();
    check({nm, "_wbeats_left"}, 32'(wq.size()), 32'd0);
    check({nm, "_rbeats_left"}, 32'(rq.size()), 32'd0);
    check({nm, "_ramwr_left"}, 32'(mq.size()), 32'd0);
    wq.delete(); rq.delete(); mq.delete(); evq.delete();
  endtask

  task automatic fill(input string nm, input logic [31:0] pa, input logic [7:0] ga, input logic [31:0] base);
    rd_base = base - 32'(rd_beats);
    push_fill(pa, ga, base, 16, 0);
    start(1'b0, 1'b1, pa, ga);
    wait_done(nm, 400);
  endtask

  task automatic writeback(input string nm, input logic [31:0] pa, input logic [7:0] ga);
    push_wb(pa, ga);
    start(1'b1, 1'b0, pa, ga);
    wait_done(nm, 400);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_ctl"}, 32'({bus_wreq, bus_rreq, mem_wreq, fault, finish}), 32'd0);
    check({nm, "_bus_addr"}, bus_addr, 32'd0);
    check({nm, "_bus_wdata"}, bus_wdata, 32'd0);
    check({nm, "_mem_raddr"}, 32'(mem_raddr), 32'd0);
    check({nm, "_mem_waddr"}, 32'(mem_waddr), 32'd0);
    check({nm, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int n;
    logic seen;
    logic [31:0] pa;
    logic [7:0]  ga;

    reset = 1'b1; wtrig = 1'b0; rtrig = 1'b0; bus_acc = 1'b1; bus_busy = 1'b0;
    physical_addr = 32'd0; group_addr = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    cycle();

    // Writeback with latency check and ignored triggers while busy.
    busy_mode = 1;
    push_wb(32'h8000, 8'h10);
    start(1'b1, 1'b0, 32'h8000, 8'h10);
    check("first_raddr", 32'(mem_raddr), 32'h10);
    n = 0;
    while (!bus_wreq && n < 50) begin
      cycle();
      n++;
      rtrig = (n == 3);
    end
    rtrig = 1'b0;
    check("wreq_latency", 32'(n), 32'd18);
    rtrig = 1'b1; cycle();
    rtrig = 1'b0; wtrig = 1'b1; cycle();
    rtrig = 1'b1; cycle();
    wtrig = 1'b0; rtrig = 1'b0;
    wait_done("wb_basic", 400);

    // Fill with random busy.
    fill("fill_basic", 32'h8000, 8'h10, 32'd1000);

    // Long stall mid-burst, fill and writeback.
    stall_at = 6; stall_done = 1'b0;
    fill("fill_stall", $urandom, 8'($urandom), $urandom);
    stall_at = 6; stall_done = 1'b0;
    writeback("wb_stall", $urandom, 8'($urandom));
    stall_at = -1;

    // Grant lost after five fill beats.
    abort_at = 5;
    rd_base = 32'd1000 - 32'(rd_beats);
    push_fill(32'h8000, 8'h10, 32'd1000, 5, 1);
    start(1'b0, 1'b1, 32'h8000, 8'h10);
    wait_done("fill_abort", 400);
    abort_at = -1;
    bus_acc = 1'b1;
    repeat (5) cycle();

    // Both triggers together.
    evq.push_back(1);
    start(1'b1, 1'b1, 32'h4000, 8'h20);
    wait_done("both_trig", 20);
    seen = 1'b0;
    repeat (20) begin
      cycle();
      seen = seen | bus_wreq | bus_rreq;
    end
    check("both_trig_no_req", 32'(seen), 32'd0);

    // Reset in the middle of a writeback burst.
    push_wb(32'h1_2340, 8'h50);
    start(1'b1, 1'b0, 32'h1_2340, 8'h50);
    n = 0;
    while (beats_seen < 4 && n < 300) begin
      cycle();
      n++;
    end
    check("rst_mid_reached_wbus", 32'(bus_wreq), 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    wq.delete(); rq.delete(); mq.delete(); evq.delete();
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    fill("fill_after_rst", 32'hABCD_0000, 8'h30, 32'd1000);

    // Randomized mix.
    for (int k = 0; k < 6; k++) begin
      pa = $urandom;
      ga = 8'($urandom);
      if (k % 2 == 0) writeback("wb_rand", pa, ga);
      else fill("fill_rand", pa, ga, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
